// File: rtl/fma_stream_pkg.sv
// Shared types and sizing helpers for the FMA stream adapter.
// Result entries are sized for the widest supported configuration.
package fma_stream_pkg;

  localparam int MaxDataWidth = 32;
  localparam int MaxTagWidth  = 16;

  typedef struct packed {
    logic [MaxDataWidth-1:0] result;
    logic [MaxTagWidth-1:0]  tag;
  } result_entry_t;

  // Counter must represent 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fma_result_fifo.sv
// Result buffer: circular FIFO of result entries, any depth.
// Push while full is accepted only when a pop happens in the same cycle.
module fma_result_fifo
  import fma_stream_pkg::*;
#(
  parameter int Depth = 3,
  localparam int CntW = cnt_width(Depth),
  localparam int PtrW = ptr_width(Depth)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  result_entry_t wdata,
  input  logic          pop,
  output result_entry_t rdata,
  output logic          full,
  output logic          empty,
  output logic [CntW-1:0] count
);

  result_entry_t   mem [Depth];
  logic [PtrW-1:0] wr_ptr;
  logic [PtrW-1:0] rd_ptr;
  logic            do_push;
  logic            do_pop;

  function automatic logic [PtrW-1:0] next_ptr(
    input logic [PtrW-1:0] p
  );
    if (p == PtrW'(Depth - 1)) begin
      return '0;
    end
    return p + PtrW'(1);
  endfunction

  assign full    = (count == CntW'(Depth));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CntW'(1);
        2'b01:   count <= count - CntW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (do_push && !rst) begin
      mem[wr_ptr] <= wdata;
    end
  end

endmodule

// File: rtl/fma_stream_adapter.sv
// Valid/ready wrapper around a fixed-latency FMA core.
// Credits cover in-flight ops plus buffered results, so the FIFO never overflows.
module fma_stream_adapter
  import fma_stream_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter int Latency   = 1,
  parameter int TagWidth  = 4,
  parameter int FifoDepth = Latency + 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [DataWidth-1:0] in_a_i,
  input  logic [DataWidth-1:0] in_b_i,
  input  logic [DataWidth-1:0] in_c_i,
  input  logic                 in_neg_a_i,
  input  logic                 in_neg_c_i,
  input  logic [TagWidth-1:0]  in_tag_i,
  output logic [DataWidth-1:0] fma_a_o,
  output logic [DataWidth-1:0] fma_b_o,
  output logic [DataWidth-1:0] fma_c_o,
  output logic                 fma_neg_a_o,
  output logic                 fma_neg_c_o,
  input  logic [DataWidth-1:0] fma_result_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [DataWidth-1:0] out_result_o,
  output logic [TagWidth-1:0]  out_tag_o
);

  localparam int CntW = cnt_width(FifoDepth);
  localparam int SumW = cnt_width(FifoDepth + Latency);

  if (Latency < 1 || Latency > 6) begin : g_bad_latency
    $error("fma_stream_adapter: Latency must be 1..6");
  end
  if (FifoDepth < Latency + 1) begin : g_bad_depth
    $error("fma_stream_adapter: FifoDepth must be >= Latency+1");
  end
  if (DataWidth != 16 && DataWidth != 32) begin : g_bad_width
    $error("fma_stream_adapter: DataWidth must be 16 or 32");
  end
  if (TagWidth < 1 || TagWidth > MaxTagWidth) begin : g_bad_tag
    $error("fma_stream_adapter: TagWidth out of range");
  end

  logic                issue;
  logic [Latency-1:0]  sr_vld;
  logic [TagWidth-1:0] sr_tag [Latency];
  logic [SumW-1:0]     inflight;
  logic [CntW-1:0]     fifo_count;
  logic                fifo_full;
  logic                fifo_empty;
  result_entry_t       wr_entry;
  result_entry_t       rd_entry;
  logic                unused_bits;

  assign fma_a_o     = in_a_i;
  assign fma_b_o     = in_b_i;
  assign fma_c_o     = in_c_i;
  assign fma_neg_a_o = in_neg_a_i;
  assign fma_neg_c_o = in_neg_c_i;

  // Only registered state feeds the credit check.
  assign in_ready_o = (inflight + SumW'(fifo_count)) < SumW'(FifoDepth);
  assign issue      = in_valid_i && in_ready_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sr_vld <= '0;
    end else begin
      sr_vld[0] <= issue;
      for (int i = 1; i < Latency; i++) begin
        sr_vld[i] <= sr_vld[i-1];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    sr_tag[0] <= in_tag_i;
    for (int i = 1; i < Latency; i++) begin
      sr_tag[i] <= sr_tag[i-1];
    end
  end

  always_comb begin
    inflight = '0;
    for (int i = 0; i < Latency; i++) begin
      inflight = inflight + SumW'(sr_vld[i]);
    end
  end

  always_comb begin
    wr_entry = '0;
    wr_entry.result[DataWidth-1:0] = fma_result_i;
    wr_entry.tag[TagWidth-1:0]     = sr_tag[Latency-1];
  end

  fma_result_fifo #(
    .Depth (FifoDepth)
  ) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (sr_vld[Latency-1]),
    .wdata (wr_entry),
    .pop   (out_ready_i),
    .rdata (rd_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign out_valid_o  = !fifo_empty;
  assign out_result_o = rd_entry.result[DataWidth-1:0];
  assign out_tag_o    = rd_entry.tag[TagWidth-1:0];
  assign unused_bits  = ^{rd_entry, fifo_full};

endmodule
